register_file_be: RTL and testbench

- Parametrised successor to the fixed-width enabled register: a DEPTH-entry by DATA_W-bit register file for the Factorial datapath.
- Provides one synchronous write port with per-byte write enables and two independent combinational read ports.
- Keeps a per-entry valid flag, supports a single-cycle clear-all command, and offers optional write-to-read bypass.
- Intended as the operand/result store between the Factorial controller and the multiplier.

---
 rtl/register_file_be_pkg.sv | 16 +
 rtl/register_file_be_entry.sv | 29 ++
 rtl/register_file_be.sv | 64 ++++++
 tb/tb_register_file_be.sv | 131 +++++++++++++
 4 files changed

// File: rtl/register_file_be_pkg.sv
// register_file_be_pkg: shared constants and helpers for the byte-enabled register file
package register_file_be_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_W = 256;
  localparam int MAX_B = MAX_W / BYTE_W;
  // Callers widen to MAX_W and narrow the result back to their own width
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
    for (int i = 0; i < MAX_B; i++)
      byte_merge[i*BYTE_W +: BYTE_W] = be[i] ? new_w[i*BYTE_W +: BYTE_W] : old_w[i*BYTE_W +: BYTE_W];
  endfunction
  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/register_file_be_entry.sv
// register_entry_be: one DATA_W-bit entry with per-byte enables and a valid flag
module register_entry_be
  import register_file_be_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        data,
  output logic                     valid
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  always_comb begin
    data_d = (rst || clr) ? '0 :
             we ? DATA_W'(byte_merge(MAX_W'(data_q), MAX_W'(wdata), MAX_B'(be))) : data_q;
    valid_d = !(rst || clr) && (valid_q || (we && |be));
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    valid_q <= valid_d;
  end
  assign data = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/register_file_be.sv
// register_file_be: DEPTH x DATA_W register file, byte-enabled write, two comb reads with bypass
module register_file_be
  import register_file_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wbe,
  input  logic [ADDR_W-1:0]        raddr0,
  output logic [DATA_W-1:0]        rdata0,
  output logic                     rvalid0,
  input  logic [ADDR_W-1:0]        raddr1,
  output logic [DATA_W-1:0]        rdata1,
  output logic                     rvalid1
);
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  wsel;
  logic              wr_ok, byp;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] sd [2];
  logic [DATA_W-1:0] rd [2];
  logic [1:0]        rin, hit, sv, rv;
  assign wr_ok = we && in_range(32'(waddr), DEPTH);
  // reset_n is active-high despite its name
  assign byp = (BYPASS != 0) && wr_ok && !reset_n && !clr;
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    assign wsel[e] = wr_ok && waddr == ADDR_W'(e);
    register_entry_be #(.DATA_W(DATA_W)) u_entry (
      .clk   (clk),
      .rst   (reset_n),
      .clr   (clr),
      .we    (wsel[e]),
      .be    (wbe),
      .wdata (wdata),
      .data  (ent_data[e]),
      .valid (ent_valid[e])
    );
  end
  assign ra[0] = raddr0;
  assign ra[1] = raddr1;
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rin[p] = in_range(32'(ra[p]), DEPTH);
      hit[p] = byp && ra[p] == waddr;
      sd[p] = rin[p] ? ent_data[ra[p]] : '0;
      sv[p] = rin[p] && ent_valid[ra[p]];
      rd[p] = hit[p] ? DATA_W'(byte_merge(MAX_W'(sd[p]), MAX_W'(wdata), MAX_B'(wbe))) : sd[p];
      rv[p] = sv[p] || (hit[p] && |wbe);
    end
  end
  assign rdata0 = rd[0];
  assign rvalid0 = rv[0];
  assign rdata1 = rd[1];
  assign rvalid1 = rv[1];
endmodule

// File: tb/tb_register_file_be.sv
// tb_register_file_be: directed vectors against default, no-bypass and DEPTH=6 builds
module tb_register_file_be;
  logic        clk = 0;
  logic        reset_n = 1;
  logic        clr = 0;
  logic        we = 0;
  logic [2:0]  waddr = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wbe = 0;
  logic [2:0]  raddr0 = 0, raddr1 = 0;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
  logic        a_rv0, a_rv1, b_rv0, b_rv1, c_rv0, c_rv1;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  register_file_be u_dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr0(raddr0), .rdata0(a_rd0), .rvalid0(a_rv0), .raddr1(raddr1), .rdata1(a_rd1), .rvalid1(a_rv1)
  );
  register_file_be #(.BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr0(raddr0), .rdata0(b_rd0), .rvalid0(b_rv0), .raddr1(raddr1), .rdata1(b_rd1), .rvalid1(b_rv1)
  );
  register_file_be #(.DEPTH(6)) u_d6 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr0(raddr0), .rdata0(c_rd0), .rvalid0(c_rv0), .raddr1(raddr1), .rdata1(c_rd1), .rvalid1(c_rv1)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got valid=%0b data=%h, expected valid=%0b data=%h", tag, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1; waddr = a; wdata = d; wbe = be;
    step();
    we = 0; wbe = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    raddr0 = a; raddr1 = a;
    #1;
  endtask

  initial begin
    step();
    step();
    reset_n = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check($sformatf("reset_a0_%0d", i), {a_rv0, a_rd0}, 33'h0);
      check($sformatf("reset_a1_%0d", i), {a_rv1, a_rd1}, 33'h0);
      check($sformatf("reset_d6_%0d", i), {c_rv0, c_rd0}, 33'h0);
    end
    // partial byte write merges with the previous word
    wr(3, 32'hDEADBEEF, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    check("merge_a", {a_rv0, a_rd0}, {1'b1, 32'hDE22BE44});
    check("merge_nb", {b_rv1, b_rd1}, {1'b1, 32'hDE22BE44});
    check("merge_d6", {c_rv0, c_rd0}, {1'b1, 32'hDE22BE44});
    // same-cycle bypass on both ports
    we = 1; waddr = 5; wdata = 32'hCAFEF00D; wbe = 4'b1100;
    rd(5);
    check("byp_a0", {a_rv0, a_rd0}, {1'b1, 32'hCAFE0000});
    check("byp_a1", {a_rv1, a_rd1}, {1'b1, 32'hCAFE0000});
    check("nobyp_nb0", {b_rv0, b_rd0}, 33'h0);
    step();
    we = 0; wbe = 0;
    #1;
    check("late_nb0", {b_rv0, b_rd0}, {1'b1, 32'hCAFE0000});
    check("late_a0", {a_rv0, a_rd0}, {1'b1, 32'hCAFE0000});
    // fill then clear with a concurrent write
    for (int i = 0; i < 8; i++) wr(3'(i), 32'hA0000000 + i, 4'b1111);
    rd(7);
    check("fill_a7", {a_rv0, a_rd0}, {1'b1, 32'hA0000007});
    check("fill_d6_7", {c_rv0, c_rd0}, 33'h0);
    clr = 1; we = 1; waddr = 2; wdata = 32'hFFFFFFFF; wbe = 4'b1111;
    rd(2);
    check("clr_byp_a", {a_rv0, a_rd0}, {1'b1, 32'hA0000002});
    step();
    clr = 0; we = 0; wbe = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check($sformatf("clr_a_%0d", i), {a_rv0, a_rd0}, 33'h0);
      check($sformatf("clr_nb_%0d", i), {b_rv1, b_rd1}, 33'h0);
    end
    // reset beats a concurrent write
    wr(1, 32'h55AA55AA, 4'b1111);
    reset_n = 1; we = 1; waddr = 1; wdata = 32'h12345678; wbe = 4'b1111;
    rd(1);
    check("rst_byp_a0", {a_rv0, a_rd0}, {1'b1, 32'h55AA55AA});
    check("rst_byp_a1", {a_rv1, a_rd1}, {1'b1, 32'h55AA55AA});
    step();
    reset_n = 0; we = 0; wbe = 0;
    #1;
    check("rst_a", {a_rv0, a_rd0}, 33'h0);
    check("rst_d6", {c_rv1, c_rd1}, 33'h0);
    // zero byte enables and out-of-range writes
    wr(4, 32'h44444444, 4'b1111);
    we = 1; waddr = 4; wdata = 32'hFFFFFFFF; wbe = 4'b0000;
    rd(4);
    check("be0_byp_a", {a_rv0, a_rd0}, {1'b1, 32'h44444444});
    step();
    we = 0;
    #1;
    check("be0_a", {a_rv0, a_rd0}, {1'b1, 32'h44444444});
    wr(0, 32'hFFFFFFFF, 4'b0000);
    rd(0);
    check("be0_fresh_a", {a_rv0, a_rd0}, 33'h0);
    wr(7, 32'h77777777, 4'b1111);
    wr(6, 32'h66666666, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check($sformatf("oor_d6_%0d", i), {c_rv0, c_rd0}, (i == 4) ? {1'b1, 32'h44444444} : 33'h0);
    end
    rd(7);
    check("inr_a7", {a_rv1, a_rd1}, {1'b1, 32'h77777777});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
